// File: rtl/fxp_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : fxp_div_iter
// Purpose  : Iterative signed fixed-point divider, one restoring quotient bit
//            per clock, with rounding, saturation and divide-by-zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module fxp_div_iter #(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIIA+WIFA-1:0]   dividend,
    input  logic [WIIB+WIFB-1:0]   divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WOI+WOF-1:0]     out,
    output logic                   overflow,
    output logic                   div_zero
);

    localparam int c_WA   = WIIA + WIFA;
    localparam int c_WB   = WIIB + WIFB;
    localparam int c_WO   = WOI + WOF;
    localparam int c_N    = c_WO + 1;
    localparam int c_NUMW = c_WA + 1 + WIFB + WOF + 1;
    localparam int c_DENW = c_WB + 1 + WIFA;
    localparam int c_RW   = c_DENW + 1;
    localparam int c_CMPW = c_NUMW + c_DENW + c_N;
    localparam int c_CW   = $clog2(c_N + 1);
    localparam logic c_RBIT = (ROUND != 0);

    localparam logic [c_N-1:0]  c_POS_LIM = {2'b00, {(c_WO-1){1'b1}}};
    localparam logic [c_N-1:0]  c_NEG_LIM = {2'b01, {(c_WO-1){1'b0}}};
    localparam logic [c_WO-1:0] c_OUT_MAX = {1'b0, {(c_WO-1){1'b1}}};
    localparam logic [c_WO-1:0] c_OUT_MIN = {1'b1, {(c_WO-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_sign;
    logic                r_dz;
    logic                r_ovf_mag;
    logic [c_DENW-1:0]   r_den;
    logic [c_RW-1:0]     r_rem;
    logic [c_N-1:0]      r_lo;
    logic [c_N-1:0]      r_q;
    logic [c_CW-1:0]     r_cnt;
    logic [c_WO-1:0]     r_out;
    logic                r_overflow;
    logic                r_div_zero;

    // Magnitudes carry one extra bit so the most negative operand is exact.
    logic [c_WA:0]       w_ext_a;
    logic [c_WA:0]       w_mag_a;
    logic [c_WB:0]       w_ext_b;
    logic [c_WB:0]       w_mag_b;
    logic [c_NUMW-1:0]   w_num;
    logic [c_DENW-1:0]   w_den;
    logic                w_ovf_mag;
    logic [c_RW-1:0]     w_num_hi;
    logic [c_N-1:0]      w_num_lo;

    logic [c_RW-1:0]     w_trial;
    logic                w_ge;
    logic [c_RW-1:0]     w_diff;

    logic [c_N:0]        w_q_inc;
    logic [c_N-1:0]      w_mag;
    logic                w_sat;
    logic [c_WO-1:0]     w_res;

    assign w_ext_a   = {dividend[c_WA-1], dividend};
    assign w_mag_a   = w_ext_a[c_WA] ? (~w_ext_a) + {{c_WA{1'b0}}, 1'b1} : w_ext_a;
    assign w_ext_b   = {divisor[c_WB-1], divisor};
    assign w_mag_b   = w_ext_b[c_WB] ? (~w_ext_b) + {{c_WB{1'b0}}, 1'b1} : w_ext_b;
    assign w_num     = c_NUMW'(w_mag_a) << (WIFB + WOF + 1);
    assign w_den     = c_DENW'(w_mag_b) << WIFA;
    // Quotient would need more than N bits; also true for a zero divisor.
    assign w_ovf_mag = c_CMPW'(w_num) >= (c_CMPW'(w_den) << c_N);
    assign w_num_hi  = c_RW'(w_num >> c_N);
    assign w_num_lo  = c_N'(w_num);

    assign w_trial   = {r_rem[c_RW-2:0], r_lo[c_N-1]};
    assign w_ge      = w_trial >= {1'b0, r_den};
    assign w_diff    = w_trial - {1'b0, r_den};

    assign w_q_inc   = {1'b0, r_q} + {{c_N{1'b0}}, c_RBIT};
    assign w_mag     = c_N'(w_q_inc >> 1);
    assign w_sat     = r_ovf_mag | (r_sign ? (w_mag > c_NEG_LIM) : (w_mag > c_POS_LIM));
    assign w_res     = c_WO'(r_sign ? (~w_mag) + {{(c_N-1){1'b0}}, 1'b1} : w_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CALC;
            S_CALC:  if (r_cnt == c_CW'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign     <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf_mag  <= 1'b0;
            r_den      <= '0;
            r_rem      <= '0;
            r_lo       <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_overflow <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign    <= dividend[c_WA-1] ^ divisor[c_WB-1];
                        r_dz      <= (divisor == '0);
                        r_ovf_mag <= w_ovf_mag;
                        r_den     <= w_den;
                        r_rem     <= w_num_hi;
                        r_lo      <= w_num_lo;
                        r_q       <= '0;
                        r_cnt     <= c_CW'(c_N);
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff : w_trial;
                    r_lo  <= r_lo << 1;
                    r_q   <= {r_q[c_N-2:0], w_ge};
                    r_cnt <= r_cnt - c_CW'(1);
                end
                S_FIX: begin
                    // With a zero divisor the sign is the dividend's sign alone.
                    if (r_dz || w_sat) begin
                        r_out      <= r_sign ? c_OUT_MIN : c_OUT_MAX;
                        r_overflow <= 1'b1;
                    end else begin
                        r_out      <= w_res;
                        r_overflow <= 1'b0;
                    end
                    r_div_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign overflow  = r_overflow;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire
